// File: rtl/core_delay_catch_fifo.sv
// Catch FIFO at the output of a fixed-latency delay line.
// Credit covers both stored entries and items still travelling through the delay,
// so every item that emerges has a free slot waiting for it.
module core_delay_catch_fifo #(
  parameter int unsigned Bits  = 1,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_i,
  output logic            credit_o,
  input  logic            valid_i,
  input  logic [Bits-1:0] data_i,
  output logic [Bits-1:0] data_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [CntW-1:0] count_o,
  output logic            error_o,
  input  logic            assert_on_i
);

  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [Bits-1:0] mem_q [Depth];
  logic            error_q, error_d;

  // One extra bit so the sum cannot wrap when inflight has been overdriven.
  logic [CntW:0]   occupancy;
  logic            full, empty;
  logic            pop, push, drop;
  logic            issue_err, valid_err;

  // Pointer increment with explicit wrap; Depth need not be a power of two.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    next_ptr = (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Status decode and handshake qualification, all from registered state.
  always_comb begin
    occupancy = {1'b0, count_q} + {1'b0, inflight_q};
    credit_o  = occupancy < (CntW + 1)'(Depth);
    full      = (count_q == CntW'(Depth));
    empty     = (count_q == '0);
    pop       = !empty && ready_i;
    // A pop in the same cycle frees the slot the push needs.
    push      = valid_i && (!full || pop);
    drop      = valid_i && full && !pop;
    issue_err = issue_i && !credit_o;
    valid_err = valid_i && (inflight_q == '0);
  end

  // Next-state for counters, pointers and the sticky error flag.
  always_comb begin
    count_d    = count_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    error_d    = error_q | issue_err | valid_err | drop;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Saturate at both ends: an unpaired valid never underflows, and repeated
    // credit violations cannot wrap the counter back to a small value.
    case ({issue_i, valid_i})
      2'b10:   if (inflight_q != '1) inflight_d = inflight_q + 1'b1;
      2'b01:   if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      error_q    <= error_d;
    end
  end

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Output view of the FIFO head, forced to zero while empty.
  always_comb begin
    valid_o = !empty;
    data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    count_o = count_q;
    error_o = error_q;
  end

`ifndef SYNTHESIS
  // Protocol checks, enabled at run time so deliberate violations can be exercised.
  always_ff @(posedge clk_i) begin
    if (!rst_i && assert_on_i) begin
      assert (!issue_err) else $error("issue_i asserted without credit");
      assert (!valid_err) else $error("valid_i asserted with nothing in flight");
      assert (!drop) else $error("push dropped while full");
      assert (occupancy <= (CntW + 1)'(Depth)) else $error("count + inflight exceeds Depth");
    end
  end
`endif

endmodule

// File: tb/tb_core_delay_catch_fifo.sv
// Randomised scoreboard bench for core_delay_catch_fifo behind a 3-cycle delay line.
module tb_core_delay_catch_fifo;

  localparam int unsigned BITS  = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int          LAT   = 3;

  logic            clk;
  logic            rst;
  logic            issue;
  logic [BITS-1:0] issue_d;
  logic            credit_o;
  logic            valid_in;
  logic [BITS-1:0] data_in;
  logic [BITS-1:0] data_o;
  logic            valid_o;
  logic            ready;
  logic [CW-1:0]   count_o;
  logic            error_o;
  logic            assert_on;
  logic            inj_v;
  logic [BITS-1:0] inj_d;

  // Delay line model
  logic [LAT-1:0]  dl_v;
  logic [BITS-1:0] dl_d [LAT];

  // Reference model state
  int              mdl_cnt;
  int              mdl_inf;
  bit              mdl_err;
  bit              mdl_on;
  logic [BITS-1:0] exp_q [$];

  int n_cmp;
  int n_fail;
  int hs_cnt;
  int cyc;

  core_delay_catch_fifo #(.Bits(BITS), .Depth(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .issue_i    (issue),
    .credit_o   (credit_o),
    .valid_i    (valid_in),
    .data_i     (data_in),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready),
    .count_o    (count_o),
    .error_o    (error_o),
    .assert_on_i(assert_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      dl_v <= '0;
    end else begin
      dl_v    <= {dl_v[LAT-2:0], issue};
      dl_d[0] <= issue_d;
      for (int i = 1; i < LAT; i++) dl_d[i] <= dl_d[i-1];
    end
  end

  assign valid_in = dl_v[LAT-1] | inj_v;
  assign data_in  = inj_v ? inj_d : dl_d[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a queue of stored items plus an in-flight count.
  always @(posedge clk) begin : model
    bit pop_m;
    bit acc_m;
    bit err_m;
    if (rst) begin
      mdl_cnt <= 0;
      mdl_inf <= 0;
      mdl_err <= 1'b0;
      mdl_on  <= 1'b1;
      exp_q.delete();
    end else if (mdl_on) begin
      pop_m = (mdl_cnt > 0) && ready;
      acc_m = valid_in && ((mdl_cnt < DEPTH) || pop_m);
      err_m = mdl_err;
      if (issue && (mdl_cnt + mdl_inf >= DEPTH)) err_m = 1'b1;
      if (valid_in && mdl_inf == 0) err_m = 1'b1;
      if (valid_in && !acc_m) err_m = 1'b1;
      mdl_inf <= mdl_inf + int'(issue) - int'(valid_in && mdl_inf > 0);
      mdl_cnt <= mdl_cnt + int'(acc_m) - int'(pop_m);
      mdl_err <= err_m;
      if (acc_m) exp_q.push_back(data_in);
    end
  end

  // Monitor: compares status every cycle and the head against the scoreboard.
  always @(negedge clk) begin
    if (mdl_on) begin
      check("count", 32'(count_o), 32'(mdl_cnt));
      check("credit", 32'(credit_o), 32'(mdl_cnt + mdl_inf < DEPTH));
      check("error", 32'(error_o), 32'(mdl_err));
      check("valid", 32'(valid_o), 32'(mdl_cnt > 0));
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL head: got %0h expected no item (cycle %0d)", data_o, cyc);
        end else begin
          check("head", 32'(data_o), 32'(exp_q[0]));
          if (ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end else begin
        check("data_zero", 32'(data_o), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_credit"}, 32'(credit_o), 32'd1);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_data"}, 32'(data_o), 32'd0);
    check({tag, "_count"}, 32'(count_o), 32'd0);
    check({tag, "_error"}, 32'(error_o), 32'd0);
  endtask

  task automatic random_legal(input int n);
    for (int i = 0; i < n; i++) begin
      issue   = credit_o && ($urandom_range(0, 1) == 1);
      issue_d = BITS'($urandom);
      ready   = ($urandom_range(0, 3) != 0);
      tick();
    end
    issue = 1'b0;
    ready = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    int n;
    int sent;
    int first;
    int lat;
    int hs0;
    n_cmp = 0; n_fail = 0; hs_cnt = 0; cyc = 0;
    mdl_on = 1'b0; mdl_cnt = 0; mdl_inf = 0; mdl_err = 1'b0;
    rst = 1'b1; issue = 1'b0; issue_d = '0; ready = 1'b0;
    inj_v = 1'b0; inj_d = '0; assert_on = 1'b0;
    tick(); tick();
    rst = 1'b0;
    assert_on = 1'b1;
    check_reset_outputs("reset");
    tick(); tick();

    // Credit exhaustion with the consumer stalled.
    n = 0;
    for (int i = 0; i < 10; i++) begin
      issue   = credit_o;
      issue_d = BITS'(n + 1);
      if (credit_o) n++;
      tick();
    end
    issue = 1'b0;
    check("exhaust_issues", 32'(n), 32'd4);
    check("exhaust_credit", 32'(credit_o), 32'd0);
    repeat (4) tick();
    check("fill_count", 32'(count_o), 32'd4);
    check("fill_head", 32'(data_o), 32'h1);
    check("fill_error", 32'(error_o), 32'd0);

    // Single-cycle drain returns one credit; one refill restores full.
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("drain_head", 32'(data_o), 32'h2);
    check("drain_count", 32'(count_o), 32'd3);
    check("drain_credit", 32'(credit_o), 32'd1);
    issue = 1'b1; issue_d = 8'h05;
    tick();
    issue = 1'b0;
    repeat (4) tick();
    check("refill_count", 32'(count_o), 32'd4);

    // Streaming with ready held high.
    ready = 1'b1;
    repeat (8) tick();
    check("stream_empty", 32'(count_o), 32'd0);
    hs0 = hs_cnt; sent = 0; first = -1; lat = -1;
    for (int i = 0; i < 80 && (sent < 16 || lat < 0); i++) begin
      issue   = (sent < 16) && credit_o;
      issue_d = BITS'(8'h10 + sent);
      if (issue) begin
        if (first < 0) first = cyc;
        sent++;
      end
      tick();
      if (lat < 0 && valid_o) lat = cyc - first;
    end
    issue = 1'b0;
    repeat (10) tick();
    check("stream_sent", 32'(sent), 32'd16);
    check("stream_latency", 32'(lat), 32'd4);
    check("stream_outputs", 32'(hs_cnt - hs0), 32'd16);
    check("stream_error", 32'(error_o), 32'd0);

    random_legal(300);
    check("random_error", 32'(error_o), 32'd0);

    // Protocol violations; run-time assertions are disabled for this stretch.
    assert_on = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue   = credit_o;
      issue_d = BITS'(8'h40 + i);
      tick();
    end
    issue = 1'b0;
    repeat (4) tick();
    check("viol_full", 32'(count_o), 32'd4);
    issue = 1'b1; issue_d = 8'hA5;
    tick();
    issue = 1'b0;
    check("viol_issue_err", 32'(error_o), 32'd1);
    // Pop exactly when the extra item emerges: push and pop while full.
    for (int i = 0; i < 5; i++) begin
      ready = valid_in;
      tick();
    end
    ready = 1'b0;
    check("fullpp_count", 32'(count_o), 32'd4);
    check("fullpp_head", 32'(data_o), 32'h41);
    issue = 1'b1; issue_d = 8'h5A;
    tick();
    issue = 1'b0;
    repeat (4) tick();
    check("drop_count", 32'(count_o), 32'd4);
    inj_v = 1'b1; inj_d = 8'h3C;
    tick();
    inj_v = 1'b0;
    check("orphan_error", 32'(error_o), 32'd1);
    check("orphan_count", 32'(count_o), 32'd4);
    repeat (3) tick();
    check("sticky_error", 32'(error_o), 32'd1);

    // Reset in the middle of traffic.
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue   = ($urandom_range(0, 1) == 1);
      issue_d = BITS'($urandom);
      tick();
    end
    issue = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    assert_on = 1'b1;

    random_legal(100);
    check("final_error", 32'(error_o), 32'd0);
    check("final_count", 32'(count_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_delay_catch_fifo.md
# core_delay_catch_fifo

Credit-controlled catch buffer downstream of a fixed-latency delay line. The upstream controller issues an item into the delay; the item emerges some cycles later tagged by `valid_i` and is captured here. This block holds captured items in a first-word-fall-through FIFO with a valid/ready output. Its credit output guarantees that items already in flight through the delay line always have a free slot when they emerge, so the delay line never needs to stall.

## Interface
- `Bits`, 1: data width.
- `Depth`, 4: FIFO entries; must be ≥1.

- `clk_i`  in  1  single clock; all state changes on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `issue_i`  in  1  upstream launched one item into the delay line this cycle.
- `credit_o`  out  1  upstream may assert `issue_i` this cycle.
- `valid_i`  in  1  delayed issue tag; item present on `data_i`.
- `data_i`  in  Bits  delay-line output.
- `data_o`  out  Bits  head of FIFO; all-zero when empty.
- `valid_o`  out  1  FIFO non-empty.
- `ready_i`  in  1  consumer accepts head this cycle.
- `count_o`  out  $clog2(Depth+1)  stored entries.
- `error_o`  out  1  sticky protocol-error flag.
- `assert_on_i`  in  1  enables simulation assertions; no effect on RTL behaviour.

## Operation
- State:
  - `count`: stored entries, 0..Depth.
  - `inflight`: issued but not yet emerged, 0..Depth; same width as `count`.
  - `wr_ptr`, `rd_ptr`: wrap from Depth-1 to 0; Depth need not be a power of two.
  - `mem[Depth]`: storage.
  - `error_o`.
- `credit_o = (count + inflight) < Depth`. Combinational from registers only; never depends on `issue_i`, `valid_i` or `ready_i`. Sum is computed at one extra bit to avoid wrap.
- Push: `valid_i` writes `data_i` to `mem[wr_ptr]` and advances `wr_ptr`.
  - If full and no simultaneous pop: the item is dropped, pointers and `count` are unchanged, and `error_o` is set.
- Pop: `valid_o & ready_i` advances `rd_ptr`. `ready_i` while empty is a no-op, not an error.
- `inflight`: +1 on `issue_i`, -1 on `valid_i`; both in the same cycle leaves it unchanged.
- `count`: +1 on accepted push, -1 on pop; both in the same cycle leaves it unchanged.
- Full with simultaneous push and pop: both accepted; `count` stays Depth; no error.
- Empty with simultaneous push and pop: pop is not possible (`valid_o`=0); push accepted; `count` becomes 1.
- Error conditions set `error_o` (sticky until reset):
  - `issue_i` while `credit_o`=0. The issue is still counted, because the item is physically in the delay line.
  - `valid_i` while `inflight`=0. `inflight` is held at 0 (no underflow) and the push proceeds normally.
  - Push dropped while full.
- Assertions under `assert_on_i`: each error condition above, plus `count`+`inflight` > Depth.

## Timing
- Reset values: `count`=0, `inflight`=0, pointers=0, `error_o`=0. Hence `valid_o`=0, `data_o`=0, `count_o`=0, `credit_o`=1.
- Reset asserted mid-operation: all state clears on that edge and every in-flight item is forgotten. Upstream must also reset the delay line.
- Write-to-read latency: 1 cycle. An item pushed at edge N is on `data_o` with `valid_o`=1 after edge N, i.e. in cycle N+1. No fall-through in the same cycle as `valid_i`.
- Credit update: an issue at edge N lowers the available credit from cycle N+1. A pop at edge N returns credit in cycle N+1.
- Throughput: with `ready_i` held high, one item per cycle, independent of the delay latency, as long as Depth ≥ delay latency + 1. Smaller Depth throttles issue but stays correct.
- `data_o` is a mux of `mem[rd_ptr]` gated by `valid_o`. `mem` is not reset.

## Test plan
- **Reset, then idle.** Required: `credit_o`=1, `valid_o`=0, `data_o`=0, `count_o`=0, `error_o`=0.
- **Credit exhaustion.** Depth=4, delay latency 3, `ready_i`=0; issue every cycle while `credit_o`=1, with data 0x1,0x2,… Required: exactly 4 issues occur and `credit_o` then stays 0. After emergence, `count_o`=4 and `data_o`=0x1. `error_o`=0 throughout.
- **Drain and refill.** From the full state above, pulse `ready_i` for one cycle. Required: `data_o` becomes 0x2, `count_o`=3, `credit_o`=1 in the next cycle. A single issue then restores `count_o`=4 after the latency.
- **Full-rate streaming.** Depth=4, latency 3, `ready_i`=1, issue 16 items back-to-back. Required: 16 outputs in order on consecutive cycles, 4 cycles after the first issue; pointer wrap is seamless; `error_o`=0.
- **Simultaneous push/pop when full.** Required: `count_o` remains 4, FIFO order is preserved, no error.
- **Protocol violations.** Issue with `credit_o`=0, then `valid_i` with `inflight`=0. Required: `error_o`=1 from the next cycle and held until `rst_i`. A reset mid-stream returns every output to its reset value one edge later.
